// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for mem_access_unit: size encodings, FSM states,
// store replication, load alignment/extension and misalignment detection.
package mem_access_unit_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size,
                                                  input logic [31:0] wdata);
    logic [31:0] r;
    case (size_e'(size))
      SIZE_B:  r = {4{wdata[7:0]}};
      SIZE_H:  r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                               input logic        sext,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata;
    case (size_e'(size))
      SIZE_B: begin
        sh = rdata >> {off, 3'b000};
        r  = {{24{sext & sh[7]}}, sh[7:0]};
      end
      SIZE_H: begin
        sh = rdata >> {off[1], 4'b0000};
        r  = {{16{sext & sh[15]}}, sh[15:0]};
      end
      default: r = sh;
    endcase
    return r;
  endfunction

  // Reserved size 11 behaves as a word, so it has the same alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic r;
    case (size_e'(size))
      SIZE_B:  r = 1'b0;
      SIZE_H:  r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and SRAM-like bus signals of mem_access_unit.
// slave = the unit itself, master = the pipeline plus memory around it.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              sram_req;
  logic              sram_wr;
  logic [1:0]        sram_size;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_wstrb;
  logic [31:0]       sram_wdata;
  logic              sram_addr_ok;
  logic              sram_data_ok;
  logic [31:0]       sram_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_excp;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  sram_addr_ok, sram_data_ok, sram_rdata, resp_ready,
    output req_ready, sram_req, sram_wr, sram_size, sram_addr, sram_wstrb,
    output sram_wdata, resp_valid, resp_rdata, resp_excp
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output sram_addr_ok, sram_data_ok, sram_rdata, resp_ready,
    input  req_ready, sram_req, sram_wr, sram_size, sram_addr, sram_wstrb,
    input  sram_wdata, resp_valid, resp_rdata, resp_excp
  );
endinterface

// File: rtl/mem_access_unit_decoder_2_4.sv
// 2-to-4 one-hot decoder used for byte write strobes.
module mem_access_unit_decoder_2_4 (
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);
  assign onehot_o = 4'b0001 << sel_i;
endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage controller: one load/store at a time over an
// addr_ok/data_ok bus. Define MEM_MISALIGN_EXC_EN to trap misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic              clk,
  input logic              resetn,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              misalign;
  logic [3:0]        byte_onehot;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid)    state_d = misalign ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.sram_addr_ok) state_d = ST_WAIT;
      ST_WAIT: if (bus.sram_data_ok) state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready)   state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      sext_q  <= bus.req_sext;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state_q == ST_WAIT && bus.sram_data_ok) begin
      rdata_q <= we_q ? 32'h0 : extract_load(size_q, sext_q, addr_q[1:0], bus.sram_rdata);
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  logic excp_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     excp_q <= 1'b0;
    else if (accept) excp_q <= misalign;
  end
  assign bus.resp_excp = excp_q;
`else
  assign bus.resp_excp = 1'b0;
`endif

  mem_access_unit_decoder_2_4 decoder_2_4 (
    .sel_i    (addr_q[1:0]),
    .onehot_o (byte_onehot)
  );

  // Handshake outputs are pure state decodes; ready is also held low in reset.
  always_comb begin
    bus.req_ready  = resetn && (state_q == ST_IDLE);
    bus.sram_req   = (state_q == ST_REQ);
    bus.resp_valid = (state_q == ST_RESP);
    bus.sram_wstrb = 4'b0000;
    if (we_q) begin
      case (size_e'(size_q))
        SIZE_B:  bus.sram_wstrb = byte_onehot;
        SIZE_H:  bus.sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: bus.sram_wstrb = 4'b1111;
      endcase
    end
  end

  assign bus.sram_wr    = we_q;
  assign bus.sram_size  = size_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = replicate_wdata(size_q, wdata_q);
  assign bus.resp_rdata = rdata_q;

endmodule
